// File: rtl/demux_1l2.sv
// demux_1l2: receive-side 1:2 lane demultiplexer (phy_rx), clk_2f domain.
// An interleaved byte stream carries lane 0 on even slots and lane 1 on odd slots.
// Each completed pair is presented together on every second edge, flagged by pair_stb.
// Optional feature macro: DEMUX_1L2_MISMATCH_CNT_EN adds a saturating mismatch_cnt
// that counts committed pairs whose two lane valids disagree.
module demux_1l2 #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_0,
  output logic [DATA_WIDTH-1:0] data_1,
  output logic                  valid_0,
  output logic                  valid_1,
  output logic                  pair_stb
`ifdef DEMUX_1L2_MISMATCH_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt
`endif
);

  typedef enum logic {S_LANE0 = 1'b0, S_LANE1 = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic                    commit;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    hold_valid;

  // Reject degenerate widths at elaboration time.
  if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("demux_1l2: DATA_WIDTH and CNT_WIDTH must be >= 1");
  end

  // Slot selector: alignment fixed by reset, strictly alternating afterwards.
  always_ff @(posedge clk_2f) begin
    if (reset) state <= S_LANE0;
    else       state <= state_nxt;
  end

  // Next slot and commit decode; the lane 1 slot completes the pair.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      S_LANE0: state_nxt = S_LANE1;
      S_LANE1: begin
        state_nxt = S_LANE0;
        commit    = 1'b1;
      end
      default: state_nxt = S_LANE0;
    endcase
  end

  // Lane 0 capture; an invalid slot clears valid but keeps the last good byte.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (!commit) begin
      if (valid_in) hold_data <= data_in;
      hold_valid <= valid_in;
    end
  end

  // Pair commit: both lanes update together, outputs hold across the lane 0 slot.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      data_0   <= '0;
      data_1   <= '0;
      valid_0  <= 1'b0;
      valid_1  <= 1'b0;
      pair_stb <= 1'b0;
    end else begin
      pair_stb <= commit;
      if (commit) begin
        data_0  <= hold_data;
        valid_0 <= hold_valid;
        if (valid_in) data_1 <= data_in;
        valid_1 <= valid_in;
      end
    end
  end

`ifdef DEMUX_1L2_MISMATCH_CNT_EN
  // Count commits whose lane valids disagree; sticks at all-ones.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      mismatch_cnt <= '0;
    end else if (commit && (hold_valid != valid_in) && (mismatch_cnt != '1)) begin
      mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1l2.sv
// tb_demux_1l2: directed + random bench for demux_1l2 with a per-lane
// "last good byte" reference model and per-lane FIFO ordering check.
module tb_demux_1l2;
  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_2f = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic [DW-1:0] data_0, data_1;
  logic          valid_0, valid_1, pair_stb;
`ifdef DEMUX_1L2_MISMATCH_CNT_EN
  logic [CW-1:0] mismatch_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  bit            slot;
  logic [DW-1:0] last0, last1;
  bit            pv0;
  logic [DW-1:0] e_d0, e_d1;
  logic          e_v0, e_v1, e_stb;
  int            e_cnt;
  logic [DW-1:0] q0[$], q1[$];

  demux_1l2 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_0   (data_0),
    .data_1   (data_1),
    .valid_0  (valid_0),
    .valid_1  (valid_1),
    .pair_stb (pair_stb)
`ifdef DEMUX_1L2_MISMATCH_CNT_EN
    ,
    .mismatch_cnt (mismatch_cnt)
`endif
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    slot = 0; last0 = '0; last1 = '0; pv0 = 0;
    e_d0 = '0; e_d1 = '0; e_v0 = 0; e_v1 = 0; e_stb = 0; e_cnt = 0;
    q0.delete(); q1.delete();
  endtask

  // One clk_2f edge: drive, clock, advance model, compare everything.
  task automatic step(input logic [DW-1:0] d, input logic v, input logic r, input string tag);
    logic [DW-1:0] exp_q;
    data_in = d; valid_in = v; reset = r;
    @(posedge clk_2f); #1;
    if (r) begin
      model_reset();
    end else if (!slot) begin
      if (v) begin last0 = d; q0.push_back(d); end
      pv0   = v;
      e_stb = 0;
      slot  = 1;
    end else begin
      e_d0 = last0; e_v0 = pv0;
      if (v) begin last1 = d; q1.push_back(d); end
      e_d1 = last1; e_v1 = v; e_stb = 1;
      if ((pv0 != v) && e_cnt < CMAX) e_cnt++;
      if (pv0 && q0.size() > 0) begin
        exp_q = q0.pop_front();
        chk({tag, ".q0"}, data_0, exp_q);
      end
      if (v && q1.size() > 0) begin
        exp_q = q1.pop_front();
        chk({tag, ".q1"}, data_1, exp_q);
      end
      slot = 0;
    end
    chk({tag, ".d0"},  data_0,   e_d0);
    chk({tag, ".d1"},  data_1,   e_d1);
    chk({tag, ".v0"},  valid_0,  e_v0);
    chk({tag, ".v1"},  valid_1,  e_v1);
    chk({tag, ".stb"}, pair_stb, e_stb);
`ifdef DEMUX_1L2_MISMATCH_CNT_EN
    chk({tag, ".cnt"}, mismatch_cnt, e_cnt);
`endif
  endtask

  initial begin
    model_reset();
    data_in = '0; valid_in = 0; reset = 1;

    // reset for 3 edges, then idle with valid_in=0
    for (int i = 0; i < 3; i++) step(8'hEE, 1'b1, 1'b1, "rst");
    for (int i = 0; i < 6; i++) step(8'h00, 1'b0, 1'b0, "idle");

    // two full valid pairs
    step(8'hA1, 1, 0, "p1s0"); step(8'hB1, 1, 0, "p1s1");
    step(8'hA2, 1, 0, "p2s0"); step(8'hB2, 1, 0, "p2s1");

    // invalid lane 0 slot keeps data, clears valid
    step(8'hA1, 1, 0, "h_s0"); step(8'hB1, 1, 0, "h_s1");
    step(8'hFF, 0, 0, "h_inv0"); step(8'hC3, 1, 0, "h_c3");
    chk("hold.d0", data_0, 8'hA1);
    chk("hold.v0", valid_0, 1'b0);
    chk("hold.d1", data_1, 8'hC3);

    // reset mid-pair discards the lane 0 capture
    step(8'h11, 1, 0, "mp_s0");
    step(8'h22, 1, 1, "mp_rst");
    step(8'h55, 0, 0, "mp_s0b"); step(8'h66, 1, 0, "mp_s1b");
    chk("midpair.no11", data_0, 8'h00);

    // lane 0 only pairs then a full pair; then more mismatches to saturate
    for (int i = 0; i < 3; i++) begin
      step(8'h30 + i[7:0], 1, 0, "mm_s0"); step(8'h40, 0, 0, "mm_s1");
    end
    step(8'h50, 1, 0, "mm_b0"); step(8'h51, 1, 0, "mm_b1");
    for (int i = 0; i < 5; i++) begin
      step(8'h60, 0, 0, "sat_s0"); step(8'h61 + i[7:0], 1, 0, "sat_s1");
    end

    // 100 random all-valid pairs
    for (int i = 0; i < 100; i++) begin
      step(DW'($urandom), 1, 0, "rnd_s0");
      step(DW'($urandom), 1, 0, "rnd_s1");
    end

    // random valid mix, with an occasional reset
    for (int i = 0; i < 60; i++) begin
      step(DW'($urandom), 1'($urandom), ($urandom_range(0, 29) == 0), "mix");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
